sum_reader: RTL and testbench
=============================

SUM_READER -- requirements
Module: sum_reader

Interface
REQ-001 Parameter DATA_W, default 8: memory word / sum width in bits.
REQ-002 Parameter RD_LAT, default 2: clocks from the rden-asserting edge to the edge where mem_q is valid; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ready  input  1  one-clock pulse from the summing controller: all four group sums are written.
REQ-006 address  output  5  memory read address.
REQ-007 rden  output  1  memory read enable.
REQ-008 mem_q  input  DATA_W  memory read data.
REQ-009 sum_data  output  DATA_W  current group sum.
REQ-010 sum_idx  output  2  group index of sum_data, 0..3.
REQ-011 sum_valid  output  1  sum_data/sum_idx are valid.
REQ-012 sum_ack  input  1  consumer accepts the sum on this edge when sum_valid=1.
REQ-013 busy  output  1  block owns the memory read port; the external read-port mux selects this block when busy=1.
REQ-014 done  output  1  one-clock pulse after the 4th sum is accepted.

Function
REQ-015 Group sums SHALL reside at addresses 7, 15, 23, 31, i.e. address = {sum_idx, 3'b111}.
REQ-016 States SHALL be IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE: ready=1 -> ISSUE with idx=0; busy=1 from the next edge.
- ISSUE: address={idx,3'b111}, rden=1 for exactly one clock -> WAIT.
- WAIT: RD_LAT-1 clocks -> capture mem_q into sum_data -> PRESENT.
- PRESENT: sum_valid=1; on sum_ack -> ISSUE with idx+1 if idx<3, else DONE.
- DONE: done=1 for one clock, busy=0 -> IDLE.
REQ-017 sum_data and sum_idx SHALL stay stable while sum_valid=1 and sum_ack=0.
REQ-018 With sum_ack held high, each sum SHALL occupy exactly one valid cycle; the full readout takes 4*(RD_LAT+1)+1 clocks from the ISSUE entry to done.
REQ-019 sum_ack while sum_valid=0 SHALL be ignored.
REQ-020 A ready pulse while busy=1 SHALL set a pending flag; DONE SHALL then go to ISSUE with idx=0 instead of IDLE, with busy staying high. Multiple pending pulses collapse into one.
REQ-021 A ready pulse coinciding with DONE SHALL be treated as pending.
REQ-022 idx SHALL be a 2-bit counter; it never wraps past 3 within one readout.
REQ-023 address SHALL be 0 and rden SHALL be 0 whenever the block is not in ISSUE.
REQ-024 sum_data SHALL be a registered capture of mem_q, with no arithmetic on it.

Reset
REQ-025 On reset=0, independent of clk, the block SHALL go to IDLE with address=0, rden=0, sum_data=0, sum_idx=0, sum_valid=0, busy=0, done=0, idx=0 and pending=0.
REQ-026 Reset asserted mid-readout SHALL abort the readout with no done pulse; after release, the block waits for a new ready pulse.

Structure
REQ-027 A shared package SHALL hold the state encodings, ADDR_W=5, N_GROUPS=4 and GROUP_LAST=3'b111, for reuse by the summing controller.
REQ-028 One sub-module, sum_reader_lat, SHALL implement the RD_LAT-deep rden-to-capture shift register; the FSM and counters stay in sum_reader.

Verification
REQ-029 RAM preload [7]=0x11, [15]=0x22, [23]=0x33, [31]=0x44; ready pulse; sum_ack tied to 1 -> sums 0x11/0, 0x22/1, 0x33/2, 0x44/3 at 3-clock spacing, then done. Reads are issued only to 7, 15, 23, 31.
REQ-030 Same preload with sum_ack low for 5 clocks per sum -> sum_valid and sum_data are held stable for 5 clocks each, and there is no rden activity while held.
REQ-031 Second ready pulse during the readout of idx=1 -> after done, a second full readout of 4 sums starts without returning to IDLE, and exactly one extra readout occurs.
REQ-032 reset=0 asserted in WAIT for idx=2 -> all outputs go to 0 immediately and there is no done pulse; a fresh ready pulse produces a full 4-sum readout starting at 0x11.
REQ-033 sum_ack pulsed while in IDLE and WAIT -> no state change; RD_LAT=1 and RD_LAT=4 builds -> correct data is captured in both.

Source files
------------

// File: rtl/sum_reader_pkg.sv
// sum_reader_pkg: shared constants for the group-sum readout path.
// The summing controller imports the same address layout and state codes.
package sum_reader_pkg;

  localparam int ADDR_W   = 5;
  localparam int N_GROUPS = 4;
  localparam int IDX_W    = 2;

  localparam logic [2:0] GROUP_LAST = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ISSUE   = 3'd1;
  localparam state_t ST_WAIT    = 3'd2;
  localparam state_t ST_PRESENT = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  // Each group sum lives in the last word of its 8-word group.
  function automatic logic [ADDR_W-1:0] group_addr(input logic [IDX_W-1:0] idx);
    return {idx, GROUP_LAST};
  endfunction

endpackage

// File: rtl/sum_reader_lat.sv
// sum_reader_lat: RD_LAT-deep token pipe that marks the clock in which
// memory read data is valid and must be captured on the coming edge.
// fire_i is high when the next cycle issues a read, so stage 0 lines up
// with rden and stage RD_LAT-1 lines up with the capture cycle.
module sum_reader_lat #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire_i,
  output logic capture_o
);

  logic [RD_LAT-1:0] shift_q;
  logic [RD_LAT-1:0] shift_d;

  // Advance the read token one stage per clock.
  always_comb begin
    shift_d = (shift_q << 1) | RD_LAT'(fire_i);
  end

  // Token register; reset discards any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign capture_o = shift_q[RD_LAT-1];

endmodule

// File: rtl/sum_reader.sv
// sum_reader: after the summing controller signals ready, reads the four
// group sums from memory one at a time and hands each to a consumer with
// a valid/ack handshake. A ready arriving mid-readout queues one more pass.
// RD_LAT must be in 1..4.
module sum_reader
  import sum_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic [ADDR_W-1:0] address,
  output logic              rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] sum_data,
  output logic [IDX_W-1:0]  sum_idx,
  output logic              sum_valid,
  input  logic              sum_ack,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_GROUPS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] sum_data_q, sum_data_d;
  logic [IDX_W-1:0]  sum_idx_q, sum_idx_d;
  logic              issue_next;
  logic              lat_capture;
  logic              capture_en;

  sum_reader_lat #(
    .RD_LAT(RD_LAT)
  ) u_lat (
    .clk      (clk),
    .rst_n    (reset),
    .fire_i   (issue_next),
    .capture_o(lat_capture)
  );

  // Readout sequencing, pending-request bookkeeping and data capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    capture_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (ready) pending_d = 1'b1;
        capture_en = lat_capture;
        state_d    = lat_capture ? ST_PRESENT : ST_WAIT;
      end
      ST_WAIT: begin
        if (ready) pending_d = 1'b1;
        capture_en = lat_capture;
        if (lat_capture) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (ready) pending_d = 1'b1;
        if (sum_ack) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (pending_q || ready) begin
          state_d   = ST_ISSUE;
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        idx_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    sum_data_d = capture_en ? mem_q : sum_data_q;
    sum_idx_d  = capture_en ? idx_q : sum_idx_q;

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT) ||
             (state_d == ST_PRESENT) || ((state_d == ST_DONE) && pending_d);
  end

  assign issue_next = (state_d == ST_ISSUE);

  // State, counters and output registers; reset aborts any readout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      sum_data_q <= '0;
      sum_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      sum_data_q <= sum_data_d;
      sum_idx_q  <= sum_idx_d;
    end
  end

  assign rden      = (state_q == ST_ISSUE);
  assign address   = rden ? group_addr(idx_q) : '0;
  assign sum_valid = (state_q == ST_PRESENT);
  assign done      = (state_q == ST_DONE);
  assign busy      = busy_q;
  assign sum_data  = sum_data_q;
  assign sum_idx   = sum_idx_q;

endmodule

// File: tb/tb_sum_reader.sv
// tb_sum_reader: drives three sum_reader builds (RD_LAT 2, 1, 4) from a
// shared ready/ack stream, each backed by its own latency-matched memory.
// A scoreboard expects every accepted sum to be mem[{k,3'b111}] for
// k = 0,1,2,3 in order, and counts readouts via done pulses.
module tb_sum_reader;

  localparam int DW = 8;
  localparam int NI = 3;

  typedef struct {
    logic       rdy;
    logic       ack;
    logic       valid;
    logic [7:0] data;
    logic [1:0] idx;
    logic       rd;
    logic [4:0] addr;
    logic       bsy;
    logic       dn;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ready = 1'b0;
  logic sumAck = 1'b0;

  logic [4:0]    addr     [NI];
  logic          rden     [NI];
  logic [DW-1:0] memQ     [NI];
  logic [DW-1:0] sumData  [NI];
  logic [1:0]    sumIdx   [NI];
  logic          sumValid [NI];
  logic          busy     [NI];
  logic          done     [NI];

  logic [7:0] mem [32];
  logic [7:0] stg [NI][3];
  logic [7:0] garb;

  int vectors = 0;
  int miscompares = 0;
  int expIdx   [NI];
  int accepted [NI];
  int doneCnt  [NI];
  int doneBase [NI];
  int accBase  [NI];
  vec_t tbl [15];

  always #5 clk = ~clk;

  sum_reader #(.DATA_W(DW), .RD_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .ready(ready), .address(addr[0]), .rden(rden[0]),
    .mem_q(memQ[0]), .sum_data(sumData[0]), .sum_idx(sumIdx[0]),
    .sum_valid(sumValid[0]), .sum_ack(sumAck), .busy(busy[0]), .done(done[0]));

  sum_reader #(.DATA_W(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .ready(ready), .address(addr[1]), .rden(rden[1]),
    .mem_q(memQ[1]), .sum_data(sumData[1]), .sum_idx(sumIdx[1]),
    .sum_valid(sumValid[1]), .sum_ack(sumAck), .busy(busy[1]), .done(done[1]));

  sum_reader #(.DATA_W(DW), .RD_LAT(4)) dut2 (
    .clk(clk), .reset(reset), .ready(ready), .address(addr[2]), .rden(rden[2]),
    .mem_q(memQ[2]), .sum_data(sumData[2]), .sum_idx(sumIdx[2]),
    .sum_valid(sumValid[2]), .sum_ack(sumAck), .busy(busy[2]), .done(done[2]));

  // Memory models: a read returns data RD_LAT edges after rden rises;
  // cycles without a read carry random junk so mistimed captures show.
  always @(posedge clk) begin
    garb <= 8'($urandom);
    for (int k = 0; k < NI; k++) begin
      stg[k][0] <= rden[k] ? mem[addr[k]] : 8'($urandom);
      stg[k][1] <= stg[k][0];
      stg[k][2] <= stg[k][1];
    end
  end

  assign memQ[0] = stg[0][0];
  assign memQ[1] = rden[1] ? mem[addr[1]] : garb;
  assign memQ[2] = stg[2][2];

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a);
    ready  = r;
    sumAck = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes, done pulses and read addresses, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < NI; k++) begin
        if (sumValid[k] && sumAck) begin
          checkOutput($sformatf("inst%0d sum_idx", k), sumIdx[k], expIdx[k]);
          checkOutput($sformatf("inst%0d sum_data", k), sumData[k],
                      mem[5'(expIdx[k] * 8 + 7)]);
          expIdx[k] = (expIdx[k] + 1) % 4;
          accepted[k]++;
        end
        if (done[k]) doneCnt[k]++;
        if (rden[k]) checkOutput($sformatf("inst%0d read addr low bits", k), addr[k][2:0], 7);
        else checkOutput($sformatf("inst%0d idle addr", k), addr[k], 0);
      end
    end
  end

  function automatic vec_t mk(input bit r, input bit a, input bit v, input int d,
                              input int i, input bit rd, input int ad, input bit b,
                              input bit dn);
    vec_t x;
    x.rdy = r; x.ack = a; x.valid = v; x.data = 8'(d); x.idx = 2'(i);
    x.rd = rd; x.addr = 5'(ad); x.bsy = b; x.dn = dn;
    return x;
  endfunction

  function automatic bit allReached(input int n);
    bit ok = 1'b1;
    for (int k = 0; k < NI; k++) if (doneCnt[k] < doneBase[k] + n) ok = 1'b0;
    return ok;
  endfunction

  task automatic snapBase();
    for (int k = 0; k < NI; k++) begin
      doneBase[k] = doneCnt[k];
      accBase[k]  = accepted[k];
    end
  endtask

  task automatic waitAll(input int n, input bit randAck);
    int budget = 600;
    while (budget > 0 && !allReached(n)) begin
      if (randAck) sumAck = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    tick();
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("inst%0d readouts", k), doneCnt[k] - doneBase[k], n);
      checkOutput($sformatf("inst%0d sums accepted", k), accepted[k] - accBase[k], 4 * n);
      checkOutput($sformatf("inst%0d busy after readout", k), busy[k], 0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("%s inst%0d address", tag, k), addr[k], 0);
      checkOutput($sformatf("%s inst%0d rden", tag, k), rden[k], 0);
      checkOutput($sformatf("%s inst%0d sum_data", tag, k), sumData[k], 0);
      checkOutput($sformatf("%s inst%0d sum_idx", tag, k), sumIdx[k], 0);
      checkOutput($sformatf("%s inst%0d sum_valid", tag, k), sumValid[k], 0);
      checkOutput($sformatf("%s inst%0d busy", tag, k), busy[k], 0);
      checkOutput($sformatf("%s inst%0d done", tag, k), done[k], 0);
    end
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    int budget;
    int n;

    for (int k = 0; k < NI; k++) begin
      expIdx[k] = 0; accepted[k] = 0; doneCnt[k] = 0;
    end
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[7] = 8'h11; mem[15] = 8'h22; mem[23] = 8'h33; mem[31] = 8'h44;

    // Expected per-cycle view of the RD_LAT=2 build with sum_ack held high.
    tbl[0]  = mk(1, 1, 0, 8'h00, 0, 0,  0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 8'h00, 0, 1,  7, 1, 0);
    tbl[2]  = mk(0, 1, 0, 8'h00, 0, 0,  0, 1, 0);
    tbl[3]  = mk(0, 1, 1, 8'h11, 0, 0,  0, 1, 0);
    tbl[4]  = mk(0, 1, 0, 8'h00, 0, 1, 15, 1, 0);
    tbl[5]  = mk(0, 1, 0, 8'h00, 0, 0,  0, 1, 0);
    tbl[6]  = mk(0, 1, 1, 8'h22, 1, 0,  0, 1, 0);
    tbl[7]  = mk(0, 1, 0, 8'h00, 0, 1, 23, 1, 0);
    tbl[8]  = mk(0, 1, 0, 8'h00, 0, 0,  0, 1, 0);
    tbl[9]  = mk(0, 1, 1, 8'h33, 2, 0,  0, 1, 0);
    tbl[10] = mk(0, 1, 0, 8'h00, 0, 1, 31, 1, 0);
    tbl[11] = mk(0, 1, 0, 8'h00, 0, 0,  0, 1, 0);
    tbl[12] = mk(0, 1, 1, 8'h44, 3, 0,  0, 1, 0);
    tbl[13] = mk(0, 1, 0, 8'h00, 0, 0,  0, 0, 1);
    tbl[14] = mk(0, 1, 0, 8'h00, 0, 0,  0, 0, 0);

    applyStimulus(0, 0);
    repeat (3) tick();
    checkAllZero("in reset");
    reset = 1'b1;
    tick();
    checkAllZero("after reset");

    // Basic readout, ack tied high.
    snapBase();
    for (int r = 0; r < 15; r++) begin
      checkOutput($sformatf("row%0d sum_valid", r), sumValid[0], tbl[r].valid);
      checkOutput($sformatf("row%0d rden", r), rden[0], tbl[r].rd);
      checkOutput($sformatf("row%0d address", r), addr[0], tbl[r].addr);
      checkOutput($sformatf("row%0d busy", r), busy[0], tbl[r].bsy);
      checkOutput($sformatf("row%0d done", r), done[0], tbl[r].dn);
      if (tbl[r].valid) begin
        checkOutput($sformatf("row%0d sum_data", r), sumData[0], tbl[r].data);
        checkOutput($sformatf("row%0d sum_idx", r), sumIdx[0], tbl[r].idx);
      end
      applyStimulus(tbl[r].rdy, tbl[r].ack);
      tick();
    end
    waitAll(1, 1'b0);

    // Consumer stalls for 5 clocks on each sum.
    snapBase();
    applyStimulus(1, 0);
    tick();
    applyStimulus(0, 0);
    for (int s = 0; s < 4; s++) begin
      budget = 20;
      while (budget > 0 && !sumValid[0]) begin tick(); budget--; end
      for (int c = 0; c < 5; c++) begin
        checkOutput($sformatf("hold%0d.%0d sum_valid", s, c), sumValid[0], 1);
        checkOutput($sformatf("hold%0d.%0d sum_data", s, c), sumData[0], 8'h11 * (s + 1));
        checkOutput($sformatf("hold%0d.%0d sum_idx", s, c), sumIdx[0], s);
        checkOutput($sformatf("hold%0d.%0d rden", s, c), rden[0], 0);
        tick();
      end
      sumAck = 1'b1;
      tick();
      sumAck = 1'b0;
    end
    sumAck = 1'b1;
    waitAll(1, 1'b0);

    // Second ready while idx=1 is presented queues exactly one more pass.
    snapBase();
    applyStimulus(1, 1);
    tick();
    ready = 1'b0;
    budget = 40;
    while (budget > 0 && !(sumValid[0] && sumIdx[0] == 2'd1)) begin tick(); budget--; end
    checkOutput("pending: idx1 presented", sumIdx[0], 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    budget = 40;
    while (budget > 0 && !done[0]) begin tick(); budget--; end
    checkOutput("pending: done pulse", done[0], 1);
    checkOutput("pending: busy held at done", busy[0], 1);
    tick();
    checkOutput("pending: rereads idx0 rden", rden[0], 1);
    checkOutput("pending: rereads idx0 address", addr[0], 7);
    waitAll(2, 1'b0);
    repeat (10) tick();
    for (int k = 0; k < NI; k++)
      checkOutput($sformatf("pending: inst%0d no third pass", k), doneCnt[k] - doneBase[k], 2);

    // Reset while waiting on the idx=2 read.
    applyStimulus(1, 1);
    tick();
    ready = 1'b0;
    budget = 40;
    while (budget > 0 && !(rden[0] && addr[0] == 5'd23)) begin tick(); budget--; end
    checkOutput("abort: idx2 read seen", addr[0], 23);
    tick();
    #2 reset = 1'b0;
    #1;
    checkAllZero("abort");
    for (int k = 0; k < NI; k++) expIdx[k] = 0;
    tick();
    tick();
    reset = 1'b1;
    snapBase();
    repeat (8) tick();
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("abort: inst%0d no done", k), doneCnt[k] - doneBase[k], 0);
      checkOutput($sformatf("abort: inst%0d idle busy", k), busy[k], 0);
    end
    applyStimulus(1, 1);
    tick();
    ready = 1'b0;
    waitAll(1, 1'b0);

    // Random memory contents, random ack, one or two passes each.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      snapBase();
      n = 1 + int'($urandom_range(0, 1));
      applyStimulus(1, 1'($urandom_range(0, 1)));
      tick();
      ready = 1'b0;
      if (n == 2) begin
        repeat ($urandom_range(0, 2)) begin
          sumAck = 1'($urandom_range(0, 1));
          tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
      waitAll(n, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
